conv_kxk_nch_pipe: RTL and testbench

Parametrised successor of the fixed 5x5x16 convolution unit. It performs a streaming K x K x N_CH convolution with one output channel. Input pixels arrive in raster order, all channels in parallel, with a valid qualifier. The adder tree is pipelined, and the result passes through bias add, optional ReLU and saturation before feeding the pooling stage of the CNN datapath.

---
 rtl/cnn_pkg.sv | 38 +++
 rtl/conv_window_kxk.sv | 53 +++++
 rtl/conv_kxk_nch_pipe.sv | 137 +++++++++++++
 tb/tb_conv_kxk_nch_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared arithmetic helpers for the CNN datapath (conv, pooling, FC).
// Accumulator sizing, ceil-log2 and signed saturation live here so all blocks agree.
package cnn_pkg;

  localparam int SAT_W = 64;

  // Valid/last tag that rides alongside data through the pipeline stages.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int bw, input int taps);
    return 2 * bw + clog2(taps) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_to_width(input logic signed [SAT_W-1:0] v,
                                                          input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    if (w >= SAT_W) return v;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_window_kxk.sv
// One channel's raster shift buffer and registered K x K dot product.
// The newest pixel sits at buf_q[0] and is the bottom-right tap of the window.
module conv_window_kxk
  import cnn_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int K         = 5,
  parameter int MAP_SIZE  = 28,
  parameter int ACC_W     = 26
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_en,
  input  logic signed [BIT_WIDTH-1:0]  pix,
  input  logic [K*K*BIT_WIDTH-1:0]     weights,
  output logic signed [ACC_W-1:0]      dot
);

  localparam int DEPTH = (K - 1) * MAP_SIZE + K;

  logic signed [BIT_WIDTH-1:0] buf_q [DEPTH];
  logic signed [ACC_W-1:0]     dot_d;
  logic signed [ACC_W-1:0]     dot_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (shift_en) begin
      buf_q[0] <= pix;
      for (int i = 1; i < DEPTH; i++) buf_q[i] <= buf_q[i-1];
    end
  end

  // Tap (r, c) lies (K-1-r) rows and (K-1-c) columns behind the newest pixel.
  always_comb begin
    dot_d = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        dot_d = dot_d
              + ACC_W'(buf_q[(K-1-r)*MAP_SIZE + (K-1-c)])
              * ACC_W'($signed(weights[(r*K+c)*BIT_WIDTH +: BIT_WIDTH]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dot_q <= '0;
    else      dot_q <= dot_d;
  end

  assign dot = dot_q;

endmodule

// File: rtl/conv_kxk_nch_pipe.sv
// Streaming K x K x N_CH convolution, one output channel: window counters,
// pipelined adder tree, then bias, optional ReLU and saturation.
module conv_kxk_nch_pipe
  import cnn_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int N_CH      = 16,
  parameter int K         = 5,
  parameter int MAP_SIZE  = 28
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [N_CH*BIT_WIDTH-1:0]         in_data,
  input  logic [N_CH*K*K*BIT_WIDTH-1:0]     filter,
  input  logic signed [BIT_WIDTH-1:0]       bias,
  input  logic                              relu_en,
  output logic                              out_valid,
  output logic signed [OUT_WIDTH-1:0]       out_data,
  output logic                              out_last
);

  localparam int ACC_W = acc_width(BIT_WIDTH, K * K * N_CH);
  localparam int T     = clog2(N_CH);
  localparam int P     = 1 << T;
  localparam int TQ    = (T > 0) ? T : 1;
  localparam int CW    = (clog2(MAP_SIZE) > 0) ? clog2(MAP_SIZE) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(MAP_SIZE - 1);
  localparam logic [CW-1:0] FIRST_WIN = CW'(K - 1);

  // Valid is a tag only: every stage advances each cycle and nothing stalls.
  logic [CW-1:0] col_q;
  logic [CW-1:0] row_q;
  tag_t          win_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
    end else begin
      win_q <= '0;
      if (in_valid) begin
        win_q.valid <= (row_q >= FIRST_WIN) && (col_q >= FIRST_WIN);
        win_q.last  <= (row_q == LAST_POS) && (col_q == LAST_POS);
        if (col_q == LAST_POS) begin
          col_q <= '0;
          row_q <= (row_q == LAST_POS) ? '0 : row_q + CW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  logic signed [ACC_W-1:0] dot [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    conv_window_kxk #(
      .BIT_WIDTH (BIT_WIDTH),
      .K         (K),
      .MAP_SIZE  (MAP_SIZE),
      .ACC_W     (ACC_W)
    ) u_win (
      .clk      (clk),
      .rst      (rst),
      .shift_en (in_valid),
      .pix      (in_data[c*BIT_WIDTH +: BIT_WIDTH]),
      .weights  (filter[c*K*K*BIT_WIDTH +: K*K*BIT_WIDTH]),
      .dot      (dot[c])
    );
  end

  // node[0] is the zero-padded leaf row; node[l] mirrors registered tree level l.
  logic signed [ACC_W-1:0] node   [T+1][P];
  logic signed [ACC_W-1:0] tree_q [TQ][P];
  tag_t                    tag_q  [T+1];

  always_comb begin
    for (int l = 0; l <= T; l++) begin
      for (int i = 0; i < P; i++) node[l][i] = '0;
    end
    for (int c = 0; c < N_CH; c++) node[0][c] = dot[c];
    for (int l = 1; l <= T; l++) begin
      for (int i = 0; i < P; i++) node[l][i] = tree_q[l-1][i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < TQ; l++) begin
        for (int i = 0; i < P; i++) tree_q[l][i] <= '0;
      end
      for (int l = 0; l <= T; l++) tag_q[l] <= '0;
    end else begin
      for (int l = 0; l < T; l++) begin
        for (int i = 0; i < P / 2; i++) begin
          if (i < (P >> (l + 1))) tree_q[l][i] <= node[l][2*i] + node[l][2*i+1];
        end
      end
      tag_q[0] <= win_q;
      for (int l = 1; l <= T; l++) tag_q[l] <= tag_q[l-1];
    end
  end

  logic signed [ACC_W-1:0]     biased;
  logic signed [SAT_W-1:0]     clipped;
  logic signed [OUT_WIDTH-1:0] out_data_d;
  logic                        out_valid_q;
  logic                        out_last_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;

  always_comb begin
    biased = node[T][0] + ACC_W'(bias);
    if (relu_en && (biased < 0)) biased = '0;
    clipped    = sat_to_width(SAT_W'(biased), OUT_WIDTH);
    out_data_d = OUT_WIDTH'(clipped);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= tag_q[T].valid;
      out_last_q  <= tag_q[T].valid & tag_q[T].last;
      if (tag_q[T].valid) out_data_q <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_kxk_nch_pipe.sv
// Directed bench: three instances (16ch/32b, 16ch/16b saturating, 3ch/32b) on an 8x8 map.
module tb_conv_kxk_nch_pipe;

  localparam int BW = 8;
  localparam int KK = 5;
  localparam int MS = 8;

  logic clk;
  logic rst;

  logic                       iv_a;
  logic [16*BW-1:0]           id_a;
  logic [16*KK*KK*BW-1:0]     flt_a;
  logic signed [BW-1:0]       bias_a;
  logic                       relu_a;
  logic                       ov_a, ol_a, ov_b, ol_b;
  logic signed [31:0]         od_a;
  logic signed [15:0]         od_b;

  logic                       iv_c;
  logic [3*BW-1:0]            id_c;
  logic [3*KK*KK*BW-1:0]      flt_c;
  logic signed [BW-1:0]       bias_c;
  logic                       relu_c;
  logic                       ov_c, ol_c;
  logic signed [31:0]         od_c;

  conv_kxk_nch_pipe #(.BIT_WIDTH(BW), .OUT_WIDTH(32), .N_CH(16), .K(KK), .MAP_SIZE(MS)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_data(id_a), .filter(flt_a), .bias(bias_a),
    .relu_en(relu_a), .out_valid(ov_a), .out_data(od_a), .out_last(ol_a));

  conv_kxk_nch_pipe #(.BIT_WIDTH(BW), .OUT_WIDTH(16), .N_CH(16), .K(KK), .MAP_SIZE(MS)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_data(id_a), .filter(flt_a), .bias(bias_a),
    .relu_en(relu_a), .out_valid(ov_b), .out_data(od_b), .out_last(ol_b));

  conv_kxk_nch_pipe #(.BIT_WIDTH(BW), .OUT_WIDTH(32), .N_CH(3), .K(KK), .MAP_SIZE(MS)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv_c), .in_data(id_c), .filter(flt_c), .bias(bias_c),
    .relu_en(relu_c), .out_valid(ov_c), .out_data(od_c), .out_last(ol_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic signed [63:0] exp_q[$];
  bit                 exp_l_q[$];
  longint got_a[$], got_b[$], got_c[$];
  bit     got_la[$], got_lb[$], got_lc[$];
  int     got_ca[$], got_cc[$];
  int     accept_edge;

  int wt [16][25];
  int pval;
  int bias_v;
  int relu_v;

  always @(negedge clk) begin
    if (rst && ov_a) begin got_a.push_back(longint'(od_a)); got_la.push_back(ol_a); got_ca.push_back(cyc); end
    if (rst && ov_b) begin got_b.push_back(longint'(od_b)); got_lb.push_back(ol_b); end
    if (rst && ov_c) begin got_c.push_back(longint'(od_c)); got_lc.push_back(ol_c); got_cc.push_back(cyc); end
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pix(input int pat, input int frame, input int ch, input int idx);
    case (pat)
      0:       return pval;
      1:       return idx % 8;
      default: return ((idx * 3 + ch * 5 + frame * 7) % 13) - 6;
    endcase
  endfunction

  // driver tasks
  task automatic set_weights(input int mode, input int v);
    for (int ch = 0; ch < 16; ch++) begin
      for (int t = 0; t < 25; t++) begin
        wt[ch][t] = (mode == 0) ? v : ((ch * 3 + t) % 7) - 3;
        flt_a[(ch*25+t)*BW +: BW] = BW'(wt[ch][t]);
        if (ch < 3) flt_c[(ch*25+t)*BW +: BW] = BW'(wt[ch][t]);
      end
    end
  endtask

  task automatic drive(input int sel, input int pat, input int nframes, input int npix, input bit gap);
    for (int f = 0; f < nframes; f++) begin
      for (int idx = 0; idx < npix; idx++) begin
        @(posedge clk); #1;
        if (sel == 2) begin
          iv_c = 1'b1;
          for (int ch = 0; ch < 3; ch++) id_c[ch*BW +: BW] = BW'(pix(pat, f, ch, idx));
        end else begin
          iv_a = 1'b1;
          for (int ch = 0; ch < 16; ch++) id_a[ch*BW +: BW] = BW'(pix(pat, f, ch, idx));
        end
        if (f == 0 && idx == 36) accept_edge = cyc + 1;
        if (gap) begin
          @(posedge clk); #1;
          iv_a = 1'b0;
          iv_c = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    iv_a = 1'b0;
    iv_c = 1'b0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_a.delete(); got_b.delete(); got_c.delete();
    got_la.delete(); got_lb.delete(); got_lc.delete();
    got_ca.delete(); got_cc.delete();
  endtask

  task automatic exp_fill(input int n, input longint v);
    exp_q.delete();
    exp_l_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      exp_l_q.push_back(i % 16 == 15);
    end
  endtask

  // reference: direct 2-D convolution over the raster image
  task automatic build_exp(input int nch, input int pat, input int nframes, input int outw);
    longint acc, hi, lo;
    exp_q.delete();
    exp_l_q.delete();
    hi = (64'sd1 <<< (outw - 1)) - 1;
    lo = -hi - 1;
    for (int f = 0; f < nframes; f++) begin
      for (int r = KK - 1; r < MS; r++) begin
        for (int c = KK - 1; c < MS; c++) begin
          acc = 0;
          for (int ch = 0; ch < nch; ch++)
            for (int i = 0; i < KK; i++)
              for (int j = 0; j < KK; j++)
                acc += longint'(pix(pat, f, ch, (r - KK + 1 + i) * MS + (c - KK + 1 + j))) * wt[ch][i*KK+j];
          acc += bias_v;
          if (relu_v != 0 && acc < 0) acc = 0;
          if (acc > hi) acc = hi;
          if (acc < lo) acc = lo;
          exp_q.push_back(acc);
          exp_l_q.push_back(r == MS - 1 && c == MS - 1);
        end
      end
    end
  endtask

  task automatic compare_out(input string tag, input int sel);
    longint g[$];
    bit     gl[$];
    int     n;
    case (sel)
      0:       begin g = got_a; gl = got_la; end
      1:       begin g = got_b; gl = got_lb; end
      default: begin g = got_c; gl = got_lc; end
    endcase
    check({tag, "_count"}, g.size(), exp_q.size());
    n = (g.size() < exp_q.size()) ? g.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), g[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), gl[i], exp_l_q[i]);
    end
  endtask

  initial begin
    rst = 1'b0;
    iv_a = 1'b0; id_a = '0; bias_a = '0; relu_a = 1'b0;
    iv_c = 1'b0; id_c = '0; bias_c = '0; relu_c = 1'b0;
    pval = 0; bias_v = 0; relu_v = 0; accept_edge = 0;
    set_weights(0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", ov_a, 0);
    check("rst_data_a", od_a, 0);
    check("rst_last_a", ol_a, 0);
    check("rst_valid_c", ov_c, 0);
    check("rst_data_c", od_c, 0);
    @(negedge clk) rst = 1'b1;

    // all ones: 16 channels x 25 taps = 400
    clear_got();
    pval = 1;
    drive(0, 0, 1, 64, 1'b0);
    drain();
    exp_fill(16, 400);
    compare_out("ones", 0);
    compare_out("ones_b", 1);
    check("ones_latency", (got_ca.size() > 0) ? got_ca[0] - accept_edge : -1, 6);
    check("hold_valid", ov_a, 0);
    check("hold_data", od_a, 400);

    // partial frame then asynchronous reset mid-cycle
    set_weights(1, 0);
    bias_v = 3; bias_a = 8'sd3;
    clear_got();
    drive(0, 0, 1, 20, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_rst_data_a", od_a, 0);
    check("async_rst_data_b", od_b, 0);
    check("async_rst_valid", ov_a, 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    drive(0, 1, 1, 64, 1'b0);
    drain();
    build_exp(16, 1, 1, 32);
    compare_out("ramp", 0);

    // same ramp with in_valid toggling: identical values and order
    clear_got();
    drive(0, 1, 1, 64, 1'b1);
    drain();
    compare_out("ramp_gap", 0);

    // zero pixels, negative bias, with and without ReLU
    set_weights(0, 1);
    pval = 0; bias_v = -5; bias_a = -8'sd5;
    clear_got();
    drive(0, 0, 1, 64, 1'b0);
    drain();
    exp_fill(16, -5);
    compare_out("bias_neg", 0);
    relu_v = 1; relu_a = 1'b1;
    clear_got();
    drive(0, 0, 1, 64, 1'b0);
    drain();
    exp_fill(16, 0);
    compare_out("relu", 0);

    // saturation at 16 bits; 32-bit instance shows the raw sum
    relu_v = 0; relu_a = 1'b0; bias_v = 0; bias_a = '0;
    set_weights(0, 127);
    pval = 127;
    clear_got();
    drive(0, 0, 1, 64, 1'b0);
    drain();
    exp_fill(16, 6451600);
    compare_out("sat_pos_raw", 0);
    exp_fill(16, 32767);
    compare_out("sat_pos", 1);
    pval = -128;
    clear_got();
    drive(0, 0, 1, 64, 1'b0);
    drain();
    exp_fill(16, -6502400);
    compare_out("sat_neg_raw", 0);
    exp_fill(16, -32768);
    compare_out("sat_neg", 1);

    // three channels, two back-to-back frames
    set_weights(1, 0);
    bias_v = -2; bias_c = -8'sd2;
    clear_got();
    drive(2, 2, 2, 64, 1'b0);
    drain();
    build_exp(3, 2, 2, 32);
    compare_out("nch3", 2);
    check("nch3_latency", (got_cc.size() > 0) ? got_cc[0] - accept_edge : -1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
